// File: rtl/seg7_scan_decoder.sv
// Monitors a time-multiplexed 7-segment bus and rebuilds per-digit hex values.
// A digit is captured once per dwell after STABLE_CYCLES identical one-hot samples.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [6:0]  iSEG,
    input  logic [7:0]  iDIG_SEL,
    output logic [63:0] oDIG,
    output logic [7:0]  oVALID,
    output logic [7:0]  oERR,
    output logic        oFRAME
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [14:0] sampleIn;
    logic [14:0] sampleQ;
    logic [7:0]  cnt;
    logic        captured;
    logic [7:0]  seenMask;
    logic [7:0]  newSeen;
    logic        inOneHot;
    logic        inSame;
    logic        doCapture;
    logic [7:0]  decByte;
    logic        decErr;

    assign sampleIn = {iDIG_SEL, iSEG};
    assign inOneHot = $onehot(iDIG_SEL);
    assign inSame   = (sampleIn == sampleQ);
    // cnt can only reach CNT_MAX while sampleQ holds a one-hot select
    assign doCapture = (cnt == CNT_MAX) && !captured;
    assign newSeen   = seenMask | sampleQ[14:7];

    always_comb begin
        decByte = 8'hFF;
        decErr  = 1'b0;
        case (sampleQ[6:0])
            7'b1000000: decByte = 8'h00;
            7'b1111001: decByte = 8'h01;
            7'b0100100: decByte = 8'h02;
            7'b0110000: decByte = 8'h03;
            7'b0011001: decByte = 8'h04;
            7'b0010010: decByte = 8'h05;
            7'b0000010: decByte = 8'h06;
            7'b1111000: decByte = 8'h07;
            7'b0000000: decByte = 8'h08;
            7'b0011000: decByte = 8'h09;
            7'b0001000: decByte = 8'h0A;
            7'b0000011: decByte = 8'h0B;
            7'b1000110: decByte = 8'h0C;
            7'b0100001: decByte = 8'h0D;
            7'b0000110: decByte = 8'h0E;
            7'b0001110: decByte = 8'h0F;
            default: begin
                decByte = 8'hFF;
                decErr  = 1'b1;
            end
        endcase
    end

    // cnt/captured describe the dwell that sampleQ is about to hold after this edge
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            sampleQ  <= '0;
            cnt      <= '0;
            captured <= 1'b0;
        end else begin
            sampleQ <= sampleIn;
            if (!inOneHot || !inSame) begin
                cnt      <= '0;
                captured <= 1'b0;
            end else begin
                if (cnt < CNT_MAX) begin
                    cnt <= cnt + 8'd1;
                end
                if (doCapture) begin
                    captured <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oDIG     <= '0;
            oVALID   <= '0;
            oERR     <= '0;
            oFRAME   <= 1'b0;
            seenMask <= '0;
        end else begin
            oFRAME <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                if (doCapture && sampleQ[7+n]) begin
                    oDIG[n*8 +: 8] <= decByte;
                    oVALID[n]      <= 1'b1;
                    oERR[n]        <= decErr;
                end
            end
            if (doCapture) begin
                if (newSeen == 8'hFF) begin
                    oFRAME   <= 1'b1;
                    seenMask <= '0;
                end else begin
                    seenMask <= newSeen;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random bus traffic,
// checked every cycle against a run-length based model of the display bus.
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;

    logic        iCLK;
    logic        iRST_N;
    logic [6:0]  iSEG;
    logic [7:0]  iDIG_SEL;
    logic [63:0] oDIG;
    logic [7:0]  oVALID;
    logic [7:0]  oERR;
    logic        oFRAME;

    seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSEG(iSEG), .iDIG_SEL(iDIG_SEL),
        .oDIG(oDIG), .oVALID(oVALID), .oERR(oERR), .oFRAME(oFRAME)
    );

    // clock / reset
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    logic [6:0] segTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int nChecks = 0;
    int nFails  = 0;
    int frameCount = 0;

    // behavioural model: run length of identical one-hot samples seen so far
    logic [7:0]  mDig [8];
    logic [7:0]  mValid;
    logic [7:0]  mErr;
    logic        mFrame;
    logic [7:0]  mSeen;
    logic [14:0] mLast;
    int          mRun;
    bit          mRunCaptured;
    int          mCaps;
    bit          checkEn = 0;

    function automatic logic [7:0] lookup(input logic [6:0] seg);
        for (int i = 0; i < 16; i++)
            if (segTab[i] == seg) return 8'(i);
        return 8'hFF;
    endfunction

    function automatic logic [63:0] modelDig();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = mDig[i];
        return v;
    endfunction

    always @(posedge iCLK) begin
        logic [14:0] cur;
        logic [7:0]  b;
        int          idx;
        if (!iRST_N) begin
            for (int i = 0; i < 8; i++) mDig[i] = 8'h00;
            mValid = 0; mErr = 0; mFrame = 0; mSeen = 0;
            mLast = 0; mRun = 0; mRunCaptured = 0;
            checkEn = 1;
        end else begin
            mFrame = 0;
            if (mRun >= STABLE && !mRunCaptured) begin
                idx = 0;
                for (int i = 0; i < 8; i++) if (mLast[7+i]) idx = i;
                b = lookup(mLast[6:0]);
                mDig[idx]   = b;
                mValid[idx] = 1'b1;
                mErr[idx]   = (b == 8'hFF);
                mSeen[idx]  = 1'b1;
                mCaps++;
                mRunCaptured = 1;
                if (mSeen == 8'hFF) begin
                    mFrame = 1;
                    mSeen  = 0;
                end
            end
            cur = {iDIG_SEL, iSEG};
            if ($countones(iDIG_SEL) == 1) begin
                if (cur == mLast && mRun > 0) mRun++;
                else begin mRun = 1; mRunCaptured = 0; end
            end else begin
                mRun = 0; mRunCaptured = 0;
            end
            mLast = cur;
        end
    end

    // scoreboard
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge iCLK) begin
        if (checkEn) begin
            check("oDIG",   oDIG,   modelDig());
            check("oVALID", 64'(oVALID), 64'(mValid));
            check("oERR",   64'(oERR),   64'(mErr));
            check("oFRAME", 64'(oFRAME), 64'(mFrame));
        end
        if (oFRAME === 1'b1) frameCount++;
    end

    // driver tasks: inputs change only right after a falling edge
    task automatic hold(input logic [7:0] sel, input logic [6:0] seg, input int n);
        iDIG_SEL = sel;
        iSEG     = seg;
        repeat (n) @(negedge iCLK);
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    initial begin
        int caps0;
        int frames0;
        mCaps    = 0;
        iRST_N   = 1'b0;
        iSEG     = 7'h7F;
        iDIG_SEL = 8'h00;
        repeat (2) @(negedge iCLK);
        check("reset_dig", oDIG, 64'h0);
        check("reset_valid", 64'(oVALID), 64'h0);
        iRST_N = 1'b1;

        // single digit, latency
        caps0 = mCaps;
        hold(8'h01, 7'b0110000, 4);
        check("t1_before_edge5", 64'(oVALID), 64'h0);
        hold(8'h01, 7'b0110000, 1);
        check("t1_dig0", 64'(oDIG[7:0]), 64'h03);
        check("t1_valid", 64'(oVALID), 64'h01);
        check("t1_err", 64'(oERR), 64'h00);
        hold(8'h01, 7'b0110000, 5);
        check("t1_one_capture", 64'(mCaps - caps0), 64'd1);

        // glitch rejection
        hold(8'h04, 7'b1111000, 3);
        hold(8'h04, 7'b0000000, 2);
        hold(8'h00, 7'b0000000, 2);
        check("t2_valid2", 64'(oVALID[2]), 64'h0);

        // full scans
        do_reset();
        frames0 = frameCount;
        for (int d = 0; d < 8; d++) hold(8'(1 << d), segTab[d+1], 6);
        check("t3_dig", oDIG, 64'h0807060504030201);
        check("t3_valid", 64'(oVALID), 64'hFF);
        check("t3_frames1", 64'(frameCount - frames0), 64'd1);
        for (int d = 0; d < 8; d++) hold(8'(1 << d), segTab[d+1], 6);
        check("t3_frames2", 64'(frameCount - frames0), 64'd2);

        // invalid select
        hold(8'h00, segTab[9], 10);
        hold(8'h03, segTab[9], 10);
        check("t4_dig", oDIG, 64'h0807060504030201);
        check("t4_valid", 64'(oVALID), 64'hFF);
        check("t4_err", 64'(oERR), 64'h00);

        // undecodable then recovery
        hold(8'h10, 7'b1111111, 6);
        check("t5_blank_byte", 64'(oDIG[39:32]), 64'hFF);
        check("t5_blank_err", 64'(oERR), 64'h10);
        hold(8'h10, 7'b0001000, 6);
        check("t5_a_byte", 64'(oDIG[39:32]), 64'h0A);
        check("t5_a_err", 64'(oERR), 64'h00);

        // reset mid-dwell
        hold(8'h08, segTab[3], 3);
        iRST_N = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        check("t6_dig", oDIG, 64'h0);
        check("t6_valid", 64'(oVALID), 64'h0);
        hold(8'h08, segTab[3], 4);
        check("t6_no_early", 64'(oVALID), 64'h0);
        hold(8'h08, segTab[3], 1);
        check("t6_valid3", 64'(oVALID), 64'h08);
        check("t6_dig3", 64'(oDIG[31:24]), 64'h03);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            int r;
            logic [7:0] sel;
            logic [6:0] seg;
            r = $urandom_range(0, 9);
            if (r < 8) sel = 8'(1 << r);
            else if (r == 8) sel = 8'h00;
            else sel = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 8) seg = segTab[$urandom_range(0, 15)];
            else seg = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 59) == 0) begin
                iRST_N = 1'b0;
                @(negedge iCLK);
                iRST_N = 1'b1;
            end
            hold(sel, seg, $urandom_range(1, 7));
        end
        hold(8'h00, 7'h7F, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
